// File: rtl/wnr_fifo_frame_reader.sv
// Purpose : drains exactly FRAME_LEN words from the async sample FIFO read port per start pulse
//           and presents them as a valid/ready stream with sop/eop markers.
// Latency : first m_valid RD_LATENCY+1 cycles after an accepted start; one beat per cycle sustained.
// Backpr. : m_ready low holds m_data/m_valid; reads are credit-limited so the
//           BUF_DEPTH-entry output buffer never overflows.
//
// Ports:
//   rd_clk, rd_rst_n        read-domain clock, asynchronous active-low reset
//   start                   single-cycle frame request (ignored unless idle)
//   busy, frame_done        frame in progress / one-cycle pulse after the eop handshake
//   fifo_rd_en/_data/_empty FIFO read port (data valid RD_LATENCY cycles after rd_en)
//   m_valid/m_ready/m_data  output stream, with m_sop/m_eop frame markers
//   underrun_cnt            only when WNR_FIFO_FRAME_READER_UNDERRUN_CNT_EN is defined:
//                           count of stream cycles starved by an empty FIFO
module wnr_fifo_frame_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_WIDTH  = 16,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop
`ifdef WNR_FIFO_FRAME_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Occupancy and in-flight counts must both be able to hold the value BUF_DEPTH.
  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = OCC_W + 1;

  // rd_cnt carries one extra bit so it can reach FRAME_LEN itself (e.g. 65536 with 16-bit counters).
  localparam logic [CNT_WIDTH:0]   RD_LIMIT     = (CNT_WIDTH+1)'(FRAME_LEN);
  localparam logic [CNT_WIDTH:0]   RD_ONE       = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] TX_LAST      = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] TX_ONE       = CNT_WIDTH'(1);
  localparam logic [SUM_W-1:0]     CREDIT_LIMIT = SUM_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0]     PTR_ONE      = PTR_W'(1);
  localparam logic [OCC_W-1:0]     OCC_ONE      = OCC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_WIDTH:0]    rd_cnt;
  logic [CNT_WIDTH-1:0]  tx_cnt;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [DATA_WIDTH-1:0] obuf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W-1:0]      inflight;
  logic [SUM_W-1:0]      credit_sum;
  logic                  start_acc;
  logic                  ret_vld;
  logic                  pop;
  logic                  last_beat;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if (last_beat) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign start_acc  = (state == S_IDLE) & start;
  assign busy       = (state == S_STREAM);
  assign frame_done = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Read issue: a read is only launched when a buffer slot is guaranteed for
  // its data, counting reads still travelling through the FIFO read latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(rd_pipe[i]);
    end
  end

  assign credit_sum = SUM_W'(occupancy) + SUM_W'(inflight);

  assign fifo_rd_en = (state == S_STREAM) & ~fifo_rd_empty &
                      (rd_cnt < RD_LIMIT) & (credit_sum < CREDIT_LIMIT);

  // Shift of issued reads; the oldest stage marks fifo_rd_data as valid this cycle.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign ret_vld = rd_pipe[RD_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Frame counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_cnt <= '0;
      tx_cnt <= '0;
    end else if (start_acc) begin
      rd_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (fifo_rd_en) rd_cnt <= rd_cnt + RD_ONE;
      if (pop)        tx_cnt <= tx_cnt + TX_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer: power-of-two ring, pointers wrap naturally
  // ---------------------------------------------------------------------------
  always_ff @(posedge rd_clk) begin
    if (ret_vld) obuf_mem[wr_ptr] <= fifo_rd_data;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (ret_vld) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({ret_vld, pop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stream output. m_data is forced to zero when nothing is held so the bus is
  // clean out of reset and between frames; the head entry is stable while stalled.
  // ---------------------------------------------------------------------------
  assign m_valid   = (occupancy != '0);
  assign m_data    = m_valid ? obuf_mem[rd_ptr] : '0;
  assign m_sop     = m_valid & (tx_cnt == '0);
  assign m_eop     = m_valid & (tx_cnt == TX_LAST);
  assign pop       = m_valid & m_ready;
  assign last_beat = pop & (tx_cnt == TX_LAST);

`ifdef WNR_FIFO_FRAME_READER_UNDERRUN_CNT_EN
  // Counts cycles where the frame is stalled purely because the FIFO has
  // nothing to give: buffer drained, no reads outstanding, words still owed.
  logic starved;

  assign starved = (state == S_STREAM) & (occupancy == '0) & (inflight == '0) &
                   fifo_rd_empty & (rd_cnt < RD_LIMIT);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      underrun_cnt <= '0;
    end else if (start_acc) begin
      underrun_cnt <= '0;
    end else if (starved && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
